// File: rtl/multi_channel_timer_if.sv
// Avalon-MM slave bus bundle for the multi-channel timer peripheral.
// The master modport is the bus side (CPU or bench); the slave modport is the timer.
interface multi_channel_timer_if #(
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  chipselect;
    logic                  read;
    logic                  write;
    logic [31:0]           writedata;
    logic [31:0]           readdata;

    modport master (
        output address, chipselect, read, write, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read, write, writedata,
        output readdata
    );
endinterface

// File: rtl/multi_channel_timer.sv
// NUM_CH independent countdown timers sharing one prescaler, behind an Avalon-MM slave.
// Each channel is one-shot or periodic with auto-reload, a sticky expiry flag and an IRQ enable.
module multi_channel_timer #(
    parameter int NUM_CH     = 4,
    parameter int CNT_WIDTH  = 24,
    parameter int PRE_WIDTH  = 16,
    parameter int ADDR_WIDTH = $clog2(4 * NUM_CH + 1)
) (
    input  logic                  CLOCK_50_I,
    input  logic                  RESET_I,
    multi_channel_timer_if.slave  av,
    output logic                  IRQ_O,
    output logic [NUM_CH-1:0]     EXPIRED_O
);
    localparam logic [ADDR_WIDTH-1:0] PRE_ADDR = ADDR_WIDTH'(4 * NUM_CH);

    logic                    wr_en;
    logic                    rd_en;
    logic [ADDR_WIDTH-3:0]   ch_sel;
    logic [1:0]              reg_sel;
    logic                    pre_wr;
    logic                    tick;
    logic [PRE_WIDTH-1:0]    prescale_q, prescale_d;
    logic [PRE_WIDTH-1:0]    pre_cnt_q, pre_cnt_d;
    logic [31:0]             readdata_q, readdata_d;
    logic                    irq_q, irq_d;

    logic [NUM_CH*3-1:0]         ctrl_flat;
    logic [NUM_CH*CNT_WIDTH-1:0] load_flat;
    logic [NUM_CH*CNT_WIDTH-1:0] count_flat;
    logic [NUM_CH-1:0]           expired_q_flat;
    logic [NUM_CH-1:0]           expired_d_flat;
    logic [NUM_CH-1:0]           irq_en_d_flat;

    // Write data is truncated to the register widths, so the high bits are deliberately dropped.
    logic unused_wdata;
    assign unused_wdata = ^av.writedata;

    assign wr_en   = av.chipselect && av.write;
    assign rd_en   = av.chipselect && av.read;
    assign ch_sel  = av.address[ADDR_WIDTH-1:2];
    assign reg_sel = av.address[1:0];

    // A PRESCALE write restarts the phase and suppresses the tick of that cycle.
    assign pre_wr     = wr_en && (av.address == PRE_ADDR);
    assign tick       = (pre_cnt_q == prescale_q) && !pre_wr;
    assign prescale_d = pre_wr ? av.writedata[PRE_WIDTH-1:0] : prescale_q;
    assign pre_cnt_d  = (pre_wr || (pre_cnt_q == prescale_q)) ? '0 : pre_cnt_q + PRE_WIDTH'(1);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [2:0]           ctrl_q, ctrl_d;
        logic [CNT_WIDTH-1:0] load_q, load_d;
        logic [CNT_WIDTH-1:0] count_q, count_d;
        logic                 expired_q, expired_d;
        logic                 hit;
        logic                 count_wr;
        logic                 dec;
        logic                 fire;

        assign hit      = wr_en && (ch_sel == (ADDR_WIDTH-2)'(gi));
        assign count_wr = hit && (reg_sel == 2'd2);
        // The decrement uses the pre-edge CTRL and yields to a same-cycle COUNT write.
        assign dec      = tick && ctrl_q[0] && (count_q != '0) && !count_wr;
        assign fire     = dec && (count_q == CNT_WIDTH'(1));

        always_comb begin
            ctrl_d    = ctrl_q;
            load_d    = load_q;
            count_d   = count_q;
            expired_d = expired_q;
            if (dec) begin
                if (fire) begin
                    count_d = ctrl_q[1] ? load_q : '0;
                    if (!ctrl_q[1]) begin
                        ctrl_d[0] = 1'b0;
                    end
                end else begin
                    count_d = count_q - CNT_WIDTH'(1);
                end
            end
            if (hit) begin
                case (reg_sel)
                    2'd0:    ctrl_d  = av.writedata[2:0];
                    2'd1:    load_d  = av.writedata[CNT_WIDTH-1:0];
                    2'd2:    count_d = av.writedata[CNT_WIDTH-1:0];
                    default: begin
                        if (av.writedata[0]) begin
                            expired_d = 1'b0;
                        end
                    end
                endcase
            end
            if (fire) begin
                expired_d = 1'b1;
            end
        end

        always_ff @(posedge CLOCK_50_I) begin
            if (RESET_I) begin
                ctrl_q    <= '0;
                load_q    <= '0;
                count_q   <= '0;
                expired_q <= 1'b0;
            end else begin
                ctrl_q    <= ctrl_d;
                load_q    <= load_d;
                count_q   <= count_d;
                expired_q <= expired_d;
            end
        end

        assign ctrl_flat[gi*3 +: 3]                 = ctrl_q;
        assign load_flat[gi*CNT_WIDTH +: CNT_WIDTH]  = load_q;
        assign count_flat[gi*CNT_WIDTH +: CNT_WIDTH] = count_q;
        assign expired_q_flat[gi]                   = expired_q;
        assign expired_d_flat[gi]                   = expired_d;
        assign irq_en_d_flat[gi]                    = ctrl_d[2];
    end

    always_comb begin
        readdata_d = readdata_q;
        if (rd_en) begin
            readdata_d = '0;
            if (av.address == PRE_ADDR) begin
                readdata_d = 32'(prescale_q);
            end else begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (ch_sel == (ADDR_WIDTH-2)'(c)) begin
                        case (reg_sel)
                            2'd0:    readdata_d = 32'(ctrl_flat[c*3 +: 3]);
                            2'd1:    readdata_d = 32'(load_flat[c*CNT_WIDTH +: CNT_WIDTH]);
                            2'd2:    readdata_d = 32'(count_flat[c*CNT_WIDTH +: CNT_WIDTH]);
                            default: readdata_d = 32'(expired_q_flat[c]);
                        endcase
                    end
                end
            end
        end
    end

    // IRQ is built from the next-state flags so it rises on the same edge as EXPIRED_O.
    assign irq_d = |(expired_d_flat & irq_en_d_flat);

    always_ff @(posedge CLOCK_50_I) begin
        if (RESET_I) begin
            prescale_q <= '0;
            pre_cnt_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            prescale_q <= prescale_d;
            pre_cnt_q  <= pre_cnt_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign av.readdata = readdata_q;
    assign IRQ_O       = irq_q;
    assign EXPIRED_O   = expired_q_flat;
endmodule
